// File: rtl/ser_enc_tx_if.sv
// ser_enc_tx_if: byte handshake between a byte source and the serial
// transmitter.
//
// Handshake: a byte moves on a rising clk edge where data_valid and
// data_ready are both high. data_in must be stable while data_valid is high.
// data_ready may be high or low regardless of data_valid. Once the source
// raises data_valid, it keeps data_in unchanged until the transfer.
//
// Signals
//   data_in     byte to transmit (D.x.y)
//   data_valid  data_in holds a byte for transfer
//   data_ready  transmitter can accept a byte this cycle
//
// Modports
//   master  byte source
//   slave   transmitter
interface ser_enc_tx_if #(
    parameter int packet_width = 8
);
    logic [packet_width-1:0] data_in;
    logic                    data_valid;
    logic                    data_ready;

    modport master (output data_in, output data_valid, input data_ready);
    modport slave  (input data_in, input data_valid, output data_ready);
endinterface

// File: rtl/ser_enc_tx.sv
// ser_enc_tx: 8b/10b serial transmitter with running disparity.
// - Bytes arrive over the bus handshake into a one-byte holding register.
// - Every 10 enabled cycles, a new symbol is loaded into the shift register.
//   The symbol is the held byte as a D-code, or the K28.5 comma if no byte is
//   held.
// - The symbol is shifted out LSB first, so bit 'a' goes out first.
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous reset, active low
//   enable      clock enable; all state frozen while low
//   bus         slave side of the byte handshake
//                 data_ready = !hold_full && enable
//   serial_out  serial bit stream (shift_reg[0])
//   sym_start   high while serial_out carries bit 'a'
module ser_enc_tx #(
    parameter logic [7:0] IDLE_CODE = 8'hBC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    ser_enc_tx_if.slave bus,
    output logic        serial_out,
    output logic        sym_start
);
    localparam int packet_width = 8;
    localparam int sym_width    = packet_width + 2;

    logic [packet_width-1:0] hold;
    logic                    hold_full;
    logic [sym_width-1:0]    shift_reg;
    logic [3:0]              bit_cnt;
    logic                    rd;

    logic boundary;
    logic accept;

    assign boundary       = (bit_cnt == 4'd9);
    assign bus.data_ready = !hold_full && enable;
    assign accept         = bus.data_valid && bus.data_ready;
    assign serial_out     = shift_reg[0];
    assign sym_start      = (bit_cnt == 4'd0);

    // 5b/6b table at RD-: {unbalanced, abcdei}.
    // For unbalanced entries, the RD+ code is the bitwise complement.
    function automatic logic [6:0] code6_neg(input logic [4:0] x);
        code6_neg = 7'b0;
        case (x)
            5'd0:  code6_neg = 7'b1_100111;
            5'd1:  code6_neg = 7'b1_011101;
            5'd2:  code6_neg = 7'b1_101101;
            5'd3:  code6_neg = 7'b0_110001;
            5'd4:  code6_neg = 7'b1_110101;
            5'd5:  code6_neg = 7'b0_101001;
            5'd6:  code6_neg = 7'b0_011001;
            5'd7:  code6_neg = 7'b0_111000;
            5'd8:  code6_neg = 7'b1_111001;
            5'd9:  code6_neg = 7'b0_100101;
            5'd10: code6_neg = 7'b0_010101;
            5'd11: code6_neg = 7'b0_110100;
            5'd12: code6_neg = 7'b0_001101;
            5'd13: code6_neg = 7'b0_101100;
            5'd14: code6_neg = 7'b0_011100;
            5'd15: code6_neg = 7'b1_010111;
            5'd16: code6_neg = 7'b1_011011;
            5'd17: code6_neg = 7'b0_100011;
            5'd18: code6_neg = 7'b0_010011;
            5'd19: code6_neg = 7'b0_110010;
            5'd20: code6_neg = 7'b0_001011;
            5'd21: code6_neg = 7'b0_101010;
            5'd22: code6_neg = 7'b0_011010;
            5'd23: code6_neg = 7'b1_111010;
            5'd24: code6_neg = 7'b1_110011;
            5'd25: code6_neg = 7'b0_100110;
            5'd26: code6_neg = 7'b0_010110;
            5'd27: code6_neg = 7'b1_110110;
            5'd28: code6_neg = 7'b0_001110;
            5'd29: code6_neg = 7'b1_101110;
            5'd30: code6_neg = 7'b1_011110;
            5'd31: code6_neg = 7'b1_101011;
        endcase
    endfunction

    // 3b/4b table at RD-: fghj. Entry y=7 is the primary code P7.
    function automatic logic [3:0] code4_neg(input logic [2:0] y);
        code4_neg = 4'b0;
        case (y)
            3'd0: code4_neg = 4'b1011;
            3'd1: code4_neg = 4'b1001;
            3'd2: code4_neg = 4'b0101;
            3'd3: code4_neg = 4'b1100;
            3'd4: code4_neg = 4'b1101;
            3'd5: code4_neg = 4'b1010;
            3'd6: code4_neg = 4'b0110;
            3'd7: code4_neg = 4'b1110;
        endcase
    endfunction

    logic                 is_k;
    logic [4:0]           x;
    logic [2:0]           y;
    logic [6:0]           e6;
    logic [5:0]           six;
    logic                 rd6;
    logic                 use_a7;
    logic [3:0]           four_neg;
    logic                 four_unbal;
    logic [3:0]           four;
    logic                 rd_next;
    logic [sym_width-1:0] sym;
    logic [sym_width-1:0] sym_lsb_first;

    always_comb begin
        is_k = !hold_full;
        x    = is_k ? IDLE_CODE[4:0] : hold[4:0];
        y    = is_k ? IDLE_CODE[7:5] : hold[7:5];

        // The K28 sub-block is 001111 at RD-. Only K28.5 is sent, so only
        // the x=28 control code is needed here.
        e6 = is_k ? 7'b1_001111 : code6_neg(x);
        // D.7 is balanced but forced-polarity, so it flips at RD+ as well.
        six = (rd && (e6[6] || (!is_k && x == 5'd7))) ? ~e6[5:0] : e6[5:0];
        rd6 = rd ^ e6[6];

        // A7 avoids a run of five equal bits across the i/f boundary.
        use_a7 = !is_k && (y == 3'd7) &&
                 ((!rd6 && (x == 5'd17 || x == 5'd18 || x == 5'd20)) ||
                  ( rd6 && (x == 5'd11 || x == 5'd13 || x == 5'd14)));
        four_neg   = use_a7 ? 4'b0111 : code4_neg(y);
        four_unbal = (y == 3'd0) || (y == 3'd4) || (y == 3'd7);

        if (is_k) begin
            // K28.y selects its 4b polarity opposite to the D rule. After
            // 001111 (rd6=+), the 4b code is the table entry; after 110000,
            // it is the complement.
            four = rd6 ? four_neg : ~four_neg;
        end else if (rd6 && (four_unbal || y == 3'd3)) begin
            four = ~four_neg;
        end else begin
            four = four_neg;
        end
        rd_next = rd6 ^ four_unbal;

        sym = {six, four};  // abcdei fghj, a in the MSB
        for (int i = 0; i < sym_width; i++) begin
            sym_lsb_first[i] = sym[sym_width-1-i];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            hold      <= '0;
            hold_full <= 1'b0;
            shift_reg <= '0;
            bit_cnt   <= 4'd9;
            rd        <= 1'b0;
        end else if (enable) begin
            if (boundary) begin
                shift_reg <= sym_lsb_first;
                bit_cnt   <= 4'd0;
                rd        <= rd_next;
            end else begin
                shift_reg <= shift_reg >> 1;
                bit_cnt   <= bit_cnt + 4'd1;
            end
            // accept implies hold_full=0, so a boundary that consumed the
            // hold cannot coincide with a new byte landing in it.
            if (accept) begin
                hold      <= bus.data_in;
                hold_full <= 1'b1;
            end else if (boundary) begin
                hold_full <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_ser_enc_tx.sv
// tb_ser_enc_tx: scoreboarded bench for ser_enc_tx.
// - A byte accepted at enabled edge E is expected as the data symbol that
//   starts at the next multiple-of-10 enabled edge after E.
// - Every other symbol is expected to be a K28.5 comma.
// - Expected symbols come from a table-plus-disparity-rule 8b/10b reference.
module tb_ser_enc_tx;
    localparam int W = 40;  // {boundary edge index[31:0], byte[7:0]}

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic enable = 1'b0;
    logic serial_out;
    logic sym_start;

    ser_enc_tx_if bus ();

    ser_enc_tx dut (
        .clk(clk),
        .rst(rst),
        .enable(enable),
        .bus(bus),
        .serial_out(serial_out),
        .sym_start(sym_start)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    logic [W-1:0] exp_q[$];

    logic [5:0] t6 [32] = '{
        6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
        6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
        6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
        6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011};
    logic [3:0] t4 [8] = '{4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110};

    // Returns {rd_out, abcdeifghj}.
    function automatic logic [10:0] ref_enc(input logic [7:0] b, input logic k, input logic rd_in);
        logic [4:0] x;
        logic [2:0] y;
        logic [5:0] c6;
        logic [3:0] c4;
        logic       r;
        logic       a7;
        if (k) return rd_in ? {1'b0, 10'b1100000101} : {1'b1, 10'b0011111010};
        x  = b[4:0];
        y  = b[7:5];
        c6 = t6[x];
        if (rd_in && ($countones(c6) != 3 || x == 5'd7)) c6 = ~c6;
        r  = rd_in ^ ($countones(c6) != 3);
        a7 = (y == 3'd7) && (r ? (x == 5'd11 || x == 5'd13 || x == 5'd14)
                               : (x == 5'd17 || x == 5'd18 || x == 5'd20));
        c4 = a7 ? 4'b0111 : t4[y];
        if (r && ($countones(c4) != 2 || y == 3'd3)) c4 = ~c4;
        return {r ^ ($countones(c4) != 2), c6, c4};
    endfunction

    function automatic void chk(input string nm, input logic [9:0] act, input logic [9:0] expv, input int at);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %b, expected %b (enabled edge %0d)", nm, act, expv, at);
        end
    endfunction

    // ---------------- monitor / scoreboard ----------------
    int          n = -1;        // enabled edges since reset, -1 = none yet
    int          pend_b = -1;   // boundary of the most recently accepted byte
    int          sym_idx = 0;
    int          bnd;
    bit          started = 0;
    bit          adv = 0;
    bit          was_rst = 0;
    bit          rdy_q = 0;
    bit          cur_is_data = 0;
    logic        m_rd = 1'b0;
    logic        cur_rd_in = 1'b0;
    logic        last_bit = 1'b0;
    logic [7:0]  cur_byte = 8'h00;
    logic [9:0]  cur_exp = 10'b0;
    logic [9:0]  sym_acc = 10'b0;
    logic [10:0] enc_r;
    logic [W-1:0] ent;

    always @(posedge clk) begin
        adv = 0;
        was_rst = 0;
        if (!rst) begin
            started = 1; was_rst = 1; n = -1; pend_b = -1; sym_idx = 0;
            m_rd = 1'b0; last_bit = 1'b0; cur_is_data = 0;
            exp_q.delete();
        end else if (started && enable) begin
            adv = 1;
            n++;
            if (bus.data_valid && rdy_q) begin
                bnd = (n / 10 + 1) * 10;
                exp_q.push_back({bnd[31:0], bus.data_in});
                pend_b = bnd;
            end
            if (n % 10 == 0) begin
                cur_rd_in = m_rd;
                cur_is_data = 0;
                if (exp_q.size() != 0 && int'(exp_q[0][39:8]) == n) begin
                    ent = exp_q.pop_front();
                    cur_is_data = 1;
                    cur_byte = ent[7:0];
                    enc_r = ref_enc(cur_byte, 1'b0, m_rd);
                end else begin
                    enc_r = ref_enc(8'hBC, 1'b1, m_rd);
                end
                cur_exp = enc_r[9:0];
                m_rd = enc_r[10];
            end
        end
    end

    always @(negedge clk) begin
        rdy_q = bus.data_ready;
        if (started) begin
            chk("data_ready", {9'b0, bus.data_ready}, {9'b0, enable && !(pend_b > n)}, n);
            if (was_rst) begin
                chk("reset_serial", {9'b0, serial_out}, 10'b0, n);
                chk("reset_sym_start", {9'b0, sym_start}, 10'b0, n);
            end else if (adv) begin
                chk("sym_start", {9'b0, sym_start}, {9'b0, (n % 10) == 0}, n);
                sym_acc = {sym_acc[8:0], serial_out};
                last_bit = serial_out;
                if (n % 10 == 9) begin
                    chk(cur_is_data ? "data_symbol" : "idle_symbol", sym_acc, cur_exp, n);
                    if (sym_idx == 0) chk("first_comma_rdneg", sym_acc, 10'b0011111010, n);
                    if (sym_idx == 1 && !cur_is_data) chk("second_comma_rdpos", sym_acc, 10'b1100000101, n);
                    if (cur_is_data && cur_byte == 8'h00)
                        chk("d0_0", sym_acc, cur_rd_in ? 10'b0110001011 : 10'b1001110100, n);
                    if (cur_is_data && cur_byte == 8'hB5)
                        chk("d21_5", sym_acc, 10'b1010101010, n);
                    if (cur_is_data && cur_byte == 8'hF1)
                        chk("d17_7", sym_acc, cur_rd_in ? 10'b1000110001 : 10'b1000110111, n);
                    sym_idx++;
                end
            end else begin
                chk("frozen_serial", {9'b0, serial_out}, {9'b0, last_bit}, n);
                chk("frozen_sym_start", {9'b0, sym_start}, {9'b0, n >= 0 && (n % 10) == 0}, n);
            end
        end
    end

    // ---------------- clock / reset / drivers ----------------
    bit jitter_on = 0;

    always @(posedge clk) begin
        if (jitter_on) begin
            #1;
            enable = ($urandom_range(0, 7) != 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit ok = 0;
        bit r;
        bus.data_in = b;
        bus.data_valid = 1'b1;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            r = bus.data_ready;
            @(posedge clk);
            if (r && rst && enable) ok = 1;
            #1;
        end
        bus.data_valid = 1'b0;
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL accept_timeout: got no transfer of %h, expected one within 200 cycles", b);
        end
    endtask

    task automatic wait_data_pos(input int p);
        bit hit = 0;
        for (int i = 0; i < 100 && !hit; i++) begin
            @(negedge clk);
            if (cur_is_data && n >= 0 && (n % 10) == p) hit = 1;
        end
        total++;
        if (!hit) begin
            bad++;
            $display("FAIL wait_pos: got no data bit %0d, expected one within 100 cycles", p);
        end
    endtask

    initial begin
        bus.data_in = 8'h00;
        bus.data_valid = 1'b0;
        rst = 1'b0;
        enable = 1'b1;
        repeat (3) tick();
        rst = 1'b1;
        repeat (45) tick();

        send_byte(8'h00);
        repeat (25) tick();
        send_byte(8'h00);
        repeat (37) tick();

        for (int i = 0; i < 4; i++) send_byte(8'hB5);
        repeat (25) tick();

        send_byte(8'hF1);
        send_byte(8'hF1);
        repeat (25) tick();

        send_byte(8'h47);
        wait_data_pos(4);
        @(posedge clk); #1;
        enable = 1'b0;
        repeat (3) tick();
        enable = 1'b1;
        repeat (25) tick();

        send_byte(8'h3C);
        send_byte(8'h5A);
        wait_data_pos(3);
        @(posedge clk); #1;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        repeat (30) tick();

        jitter_on = 1;
        for (int i = 0; i < 300; i++) begin
            repeat ($urandom_range(0, 15)) tick();
            send_byte(8'($urandom_range(0, 255)));
        end
        jitter_on = 0;
        tick();
        enable = 1'b1;
        repeat (40) tick();

        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d bytes never transmitted, expected 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
